// File: rtl/ddr_burst_seq_if.sv
// Bundle of upstream write/read handshakes and DDR2 driver port-2/3 signals for ddr_burst_seq.
// The sequencer attaches through the slave modport; producers and the driver model use master.
interface ddr_burst_seq_if #(
   parameter int unsigned ADDR_WIDTH = 30,
   parameter int unsigned DATA_WIDTH = 32
);
   logic [DATA_WIDTH-1:0] in_data;
   logic                  in_valid;
   logic                  in_ready;
   logic                  wr_flush;
   logic                  wr_err;
   logic                  rd_start;
   logic [ADDR_WIDTH-1:0] rd_base;
   logic [15:0]           rd_bursts;
   logic                  rd_busy;
   logic                  rd_done;
   logic [DATA_WIDTH-1:0] out_data;
   logic                  out_valid;
   logic                  app_w_enable;
   logic                  app_r_enable;
   logic [DATA_WIDTH-1:0] app_data_wr;
   logic                  app_data_wr_valid;
   logic [ADDR_WIDTH-1:0] app_addr_wr;
   logic                  app_addr_wr_valid;
   logic [ADDR_WIDTH-1:0] app_addr_rd;
   logic                  app_addr_rd_valid;
   logic [DATA_WIDTH-1:0] app_data_rd;
   logic                  app_data_rd_valid;

   modport slave (
      input  in_data, in_valid, wr_flush, rd_start, rd_base, rd_bursts,
             app_w_enable, app_r_enable, app_data_rd, app_data_rd_valid,
      output in_ready, wr_err, rd_busy, rd_done, out_data, out_valid,
             app_data_wr, app_data_wr_valid, app_addr_wr, app_addr_wr_valid,
             app_addr_rd, app_addr_rd_valid
   );

   modport master (
      output in_data, in_valid, wr_flush, rd_start, rd_base, rd_bursts,
             app_w_enable, app_r_enable, app_data_rd, app_data_rd_valid,
      input  in_ready, wr_err, rd_busy, rd_done, out_data, out_valid,
             app_data_wr, app_data_wr_valid, app_addr_wr, app_addr_wr_valid,
             app_addr_rd, app_addr_rd_valid
   );
endinterface

// File: rtl/ddr_burst_seq.sv
// Packs a word stream into fixed-length DDR2 write bursts and paces read-burst commands.
// Define DDR_BURST_SEQ_WRAP_EN to wrap the write address at WR_LIMIT instead of halting.
module ddr_burst_seq #(
   parameter int unsigned           ADDR_WIDTH  = 30,
   parameter int unsigned           DATA_WIDTH  = 32,
   parameter int unsigned           BURST_WORDS = 32,
   parameter logic [ADDR_WIDTH-1:0] WR_BASE     = '0,
   parameter logic [ADDR_WIDTH-1:0] WR_LIMIT    = 30'h0100_0000
) (
   input logic             c1_clk0,
   input logic             rst_n,
   ddr_burst_seq_if.slave  bus
);
   localparam int unsigned           CntW       = $clog2(BURST_WORDS);
   localparam logic [CntW-1:0]       LastCnt    = CntW'(BURST_WORDS - 1);
   localparam logic [CntW:0]         BeatFull   = (CntW + 1)'(BURST_WORDS);
   localparam logic [ADDR_WIDTH-1:0] BurstBytes = ADDR_WIDTH'(BURST_WORDS * 4);

   typedef enum logic [1:0] {WFill, WPad, WCmd, WHalt} w_state_e;
   typedef enum logic [1:0] {RIdle, RCmd, RWait} r_state_e;

   w_state_e              w_state_q, w_state_d;
   logic [CntW-1:0]       cnt_q, cnt_d;
   logic [ADDR_WIDTH-1:0] waddr_q, waddr_d, waddr_inc;
   logic                  in_ready_q, in_ready_d, err_q, err_d;
   logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
   logic                  wvalid_q, wvalid_d, awvalid_q, awvalid_d;
   logic [ADDR_WIDTH-1:0] awaddr_q, awaddr_d;
   logic                  accept;

   r_state_e              r_state_q, r_state_d;
   logic [ADDR_WIDTH-1:0] raddr_q, raddr_d, araddr_q, araddr_d;
   logic [15:0]           rem_q, rem_d;
   logic [CntW:0]         beat_q, beat_d;
   logic                  arvalid_q, arvalid_d, busy_q, busy_d, done_q, done_d;
   logic [DATA_WIDTH-1:0] out_data_q;
   logic                  out_valid_q;

   // in_ready is registered, so a late drop of app_w_enable must still block acceptance.
   assign accept    = bus.in_valid && in_ready_q && bus.app_w_enable;
   assign waddr_inc = waddr_q + BurstBytes;

   always_comb begin
      w_state_d  = w_state_q;
      cnt_d      = cnt_q;
      waddr_d    = waddr_q;
      err_d      = err_q;
      in_ready_d = 1'b0;
      wdata_d    = wdata_q;
      wvalid_d   = 1'b0;
      awaddr_d   = awaddr_q;
      awvalid_d  = 1'b0;
      unique case (w_state_q)
         WFill: begin
            if (accept) begin
               wvalid_d = 1'b1;
               wdata_d  = bus.in_data;
               cnt_d    = (cnt_q == LastCnt) ? '0 : cnt_q + 1'b1;
            end
            if (accept && cnt_q == LastCnt) begin
               w_state_d = WCmd;
            end else if (bus.wr_flush && cnt_d != '0) begin
               w_state_d = WPad;
            end else begin
               in_ready_d = bus.app_w_enable && !err_q;
            end
         end
         WPad: begin
            if (bus.app_w_enable) begin
               wvalid_d = 1'b1;
               wdata_d  = '0;
               cnt_d    = (cnt_q == LastCnt) ? '0 : cnt_q + 1'b1;
               if (cnt_q == LastCnt) w_state_d = WCmd;
            end
         end
         WCmd: begin
            awvalid_d  = 1'b1;
            awaddr_d   = waddr_q;
            w_state_d  = WFill;
            in_ready_d = bus.app_w_enable && !err_q;
            waddr_d    = waddr_inc;
            if (waddr_inc >= WR_LIMIT) begin
`ifdef DDR_BURST_SEQ_WRAP_EN
               waddr_d    = WR_BASE;
`else
               w_state_d  = WHalt;
               err_d      = 1'b1;
               in_ready_d = 1'b0;
`endif
            end
         end
         WHalt: begin
         end
         default: w_state_d = WFill;
      endcase
   end

   always_ff @(posedge c1_clk0 or negedge rst_n) begin
      if (!rst_n) begin
         w_state_q  <= WFill;
         cnt_q      <= '0;
         waddr_q    <= WR_BASE;
         err_q      <= 1'b0;
         in_ready_q <= 1'b0;
         wdata_q    <= '0;
         wvalid_q   <= 1'b0;
         awaddr_q   <= '0;
         awvalid_q  <= 1'b0;
      end else begin
         w_state_q  <= w_state_d;
         cnt_q      <= cnt_d;
         waddr_q    <= waddr_d;
         err_q      <= err_d;
         in_ready_q <= in_ready_d;
         wdata_q    <= wdata_d;
         wvalid_q   <= wvalid_d;
         awaddr_q   <= awaddr_d;
         awvalid_q  <= awvalid_d;
      end
   end

   always_comb begin
      r_state_d = r_state_q;
      raddr_d   = raddr_q;
      rem_d     = rem_q;
      beat_d    = beat_q;
      araddr_d  = araddr_q;
      arvalid_d = 1'b0;
      busy_d    = busy_q;
      done_d    = 1'b0;
      unique case (r_state_q)
         RIdle: begin
            if (bus.rd_start) begin
               if (bus.rd_bursts == '0) begin
                  done_d = 1'b1;
               end else begin
                  raddr_d   = bus.rd_base;
                  rem_d     = bus.rd_bursts;
                  busy_d    = 1'b1;
                  r_state_d = RCmd;
               end
            end
         end
         RCmd: begin
            if (bus.app_r_enable) begin
               arvalid_d = 1'b1;
               araddr_d  = raddr_q;
               raddr_d   = raddr_q + BurstBytes;
               rem_d     = rem_q - 1'b1;
               beat_d    = '0;
               r_state_d = RWait;
            end
         end
         RWait: begin
            // Decide one cycle after the last beat so rd_done trails its forwarded out_valid.
            if (beat_q == BeatFull) begin
               if (rem_q != '0) begin
                  r_state_d = RCmd;
               end else begin
                  r_state_d = RIdle;
                  busy_d    = 1'b0;
                  done_d    = 1'b1;
               end
            end else if (bus.app_data_rd_valid) begin
               beat_d = beat_q + 1'b1;
            end
         end
         default: r_state_d = RIdle;
      endcase
   end

   always_ff @(posedge c1_clk0 or negedge rst_n) begin
      if (!rst_n) begin
         r_state_q   <= RIdle;
         raddr_q     <= '0;
         rem_q       <= '0;
         beat_q      <= '0;
         araddr_q    <= '0;
         arvalid_q   <= 1'b0;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
         out_data_q  <= '0;
         out_valid_q <= 1'b0;
      end else begin
         r_state_q   <= r_state_d;
         raddr_q     <= raddr_d;
         rem_q       <= rem_d;
         beat_q      <= beat_d;
         araddr_q    <= araddr_d;
         arvalid_q   <= arvalid_d;
         busy_q      <= busy_d;
         done_q      <= done_d;
         out_data_q  <= bus.app_data_rd;
         out_valid_q <= bus.app_data_rd_valid;
      end
   end

   assign bus.in_ready          = in_ready_q;
   assign bus.wr_err            = err_q;
   assign bus.app_data_wr       = wdata_q;
   assign bus.app_data_wr_valid = wvalid_q;
   assign bus.app_addr_wr       = awaddr_q;
   assign bus.app_addr_wr_valid = awvalid_q;
   assign bus.app_addr_rd       = araddr_q;
   assign bus.app_addr_rd_valid = arvalid_q;
   assign bus.rd_busy           = busy_q;
   assign bus.rd_done           = done_q;
   assign bus.out_data          = out_data_q;
   assign bus.out_valid         = out_valid_q;
endmodule

// File: tb/tb_ddr_burst_seq.sv
// Directed bench for ddr_burst_seq: main instance with default limits, second with WR_LIMIT 0x100.
// Honors DDR_BURST_SEQ_WRAP_EN for the limit expectations.
module tb_ddr_burst_seq;
   logic c1_clk0 = 1'b0;
   logic rst_n   = 1'b0;
   always #5 c1_clk0 = ~c1_clk0;

   ddr_burst_seq_if bus ();
   ddr_burst_seq_if lb ();

   ddr_burst_seq u_dut (.c1_clk0(c1_clk0), .rst_n(rst_n), .bus(bus));
   ddr_burst_seq #(.WR_LIMIT(30'h100)) u_lim (.c1_clk0(c1_clk0), .rst_n(rst_n), .bus(lb));

   int n_vec = 0;
   int n_err = 0;
   int cyc   = 0;

   logic [31:0] wd_q[$], out_q[$];
   logic [29:0] wa_q[$], ra_q[$], lim_wa_q[$];
   int          wa_at_q[$], ra_at_q[$];
   int          n_out = 0, n_done = 0, last_out_cyc = 0, done_cyc = 0, lim_wd_n = 0;

   task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   always @(posedge c1_clk0) cyc <= cyc + 1;

   always @(negedge c1_clk0) begin
      if (bus.app_data_wr_valid) wd_q.push_back(bus.app_data_wr);
      if (bus.app_addr_wr_valid) begin
         wa_q.push_back(bus.app_addr_wr);
         wa_at_q.push_back(wd_q.size());
      end
      if (bus.out_valid) begin
         out_q.push_back(bus.out_data);
         n_out++;
         last_out_cyc = cyc;
      end
      if (bus.app_addr_rd_valid) begin
         ra_q.push_back(bus.app_addr_rd);
         ra_at_q.push_back(n_out);
      end
      if (bus.rd_done) begin
         n_done++;
         done_cyc = cyc;
      end
      if (lb.app_data_wr_valid) lim_wd_n++;
      if (lb.app_addr_wr_valid) lim_wa_q.push_back(lb.app_addr_wr);
   end

   // Driver model: 32 returned words per read command, starting two cycles later.
   initial begin
      logic [29:0] a;
      bus.app_data_rd       = '0;
      bus.app_data_rd_valid = 1'b0;
      forever begin
         @(negedge c1_clk0);
         if (bus.app_addr_rd_valid) begin
            a = bus.app_addr_rd;
            @(posedge c1_clk0); #1;
            for (int j = 0; j < 32; j++) begin
               bus.app_data_rd       = 32'(a) + 32'(j);
               bus.app_data_rd_valid = 1'b1;
               @(posedge c1_clk0); #1;
            end
            bus.app_data_rd_valid = 1'b0;
         end
      end
   end

   task automatic push_words(input int n, input int first, output int cycles);
      int  i = 0;
      bit  acc;
      cycles = 0;
      bus.in_valid = 1'b1;
      bus.in_data  = 32'(first);
      while (i < n && cycles < 1000) begin
         @(negedge c1_clk0);
         acc = bus.in_ready && bus.app_w_enable;
         @(posedge c1_clk0); #1;
         cycles++;
         if (acc) begin
            i++;
            bus.in_data = 32'(first + i);
         end
      end
      bus.in_valid = 1'b0;
      check_val("push_count", 64'(i), 64'(n));
   endtask

   task automatic wait_wcmd(input int n);
      int g = 0;
      while (wa_q.size() < n && g < 200) begin
         @(posedge c1_clk0); #1;
         g++;
      end
      check_val("wcmd_count", 64'(wa_q.size()), 64'(n));
   endtask

   task automatic clear_q();
      wd_q.delete(); wa_q.delete(); wa_at_q.delete();
   endtask

   initial begin
      int cy, g, lim_acc;
      bit acc;
      {bus.in_data, bus.in_valid, bus.wr_flush, bus.rd_start} = '0;
      {bus.rd_base, bus.rd_bursts, bus.app_w_enable, bus.app_r_enable} = '0;
      {lb.in_data, lb.in_valid, lb.wr_flush, lb.rd_start} = '0;
      {lb.rd_base, lb.rd_bursts, lb.app_w_enable, lb.app_r_enable} = '0;
      {lb.app_data_rd, lb.app_data_rd_valid} = '0;

      repeat (3) @(negedge c1_clk0);
      check_val("rst_in_ready", 64'(bus.in_ready), 64'd0);
      check_val("rst_wr_err", 64'(bus.wr_err), 64'd0);
      check_val("rst_rd_busy", 64'(bus.rd_busy), 64'd0);
      check_val("rst_strobes", 64'({bus.app_data_wr_valid, bus.app_addr_wr_valid,
                                    bus.app_addr_rd_valid, bus.out_valid, bus.rd_done}), 64'd0);
      check_val("rst_addr", 64'({bus.app_addr_wr, bus.app_addr_rd}), 64'd0);
      @(posedge c1_clk0); #1;
      rst_n = 1'b1;
      bus.app_w_enable = 1'b1;
      bus.app_r_enable = 1'b1;
      repeat (3) @(posedge c1_clk0); #1;

      // 64 back-to-back words: two bursts at 0x0 and 0x80, 65 cycles.
      push_words(64, 0, cy);
      check_val("thruput_cycles", 64'(cy), 64'd65);
      wait_wcmd(2);
      check_val("b2b_strobes", 64'(wd_q.size()), 64'd64);
      for (int i = 0; i < 64 && i < wd_q.size(); i++) check_val("b2b_data", 64'(wd_q[i]), 64'(i));
      if (wa_q.size() >= 2) begin
         check_val("b2b_cmd0", 64'(wa_q[0]), 64'h0);
         check_val("b2b_cmd0_at", 64'(wa_at_q[0]), 64'd32);
         check_val("b2b_cmd1", 64'(wa_q[1]), 64'h80);
         check_val("b2b_cmd1_at", 64'(wa_at_q[1]), 64'd64);
      end
      clear_q();

      // 10 words then flush: 22 zero pads and a command at 0x100.
      push_words(10, 100, cy);
      bus.wr_flush = 1'b1;
      @(posedge c1_clk0); #1;
      bus.wr_flush = 1'b0;
      wait_wcmd(1);
      check_val("flush_strobes", 64'(wd_q.size()), 64'd32);
      for (int i = 0; i < 32 && i < wd_q.size(); i++)
         check_val("flush_data", 64'(wd_q[i]), (i < 10) ? 64'(100 + i) : 64'd0);
      if (wa_q.size() >= 1) check_val("flush_cmd", 64'(wa_q[0]), 64'h100);
      clear_q();

      // Stall after word 15: registered in_ready is low from the second stalled cycle.
      push_words(16, 200, cy);
      bus.app_w_enable = 1'b0;
      bus.in_valid     = 1'b1;
      bus.in_data      = 32'd216;
      for (int c = 0; c < 5; c++) begin
         @(negedge c1_clk0);
         if (c > 0) check_val("stall_in_ready", 64'(bus.in_ready), 64'd0);
         @(posedge c1_clk0); #1;
      end
      @(negedge c1_clk0);
      check_val("stall_held", 64'(wd_q.size()), 64'd16);
      @(posedge c1_clk0); #1;
      bus.app_w_enable = 1'b1;
      push_words(16, 216, cy);
      wait_wcmd(1);
      repeat (3) @(posedge c1_clk0); #1;
      check_val("stall_strobes", 64'(wd_q.size()), 64'd32);
      for (int i = 0; i < 32 && i < wd_q.size(); i++) check_val("stall_data", 64'(wd_q[i]), 64'(200 + i));
      if (wa_q.size() >= 1) check_val("stall_cmd", 64'(wa_q[0]), 64'h180);
      check_val("stall_one_cmd", 64'(wa_q.size()), 64'd1);

      // Reset mid-burst: strobes drop at once, address restarts at WR_BASE.
      push_words(5, 300, cy);
      rst_n = 1'b0;
      #1;
      check_val("arst_wvalid", 64'(bus.app_data_wr_valid), 64'd0);
      check_val("arst_in_ready", 64'(bus.in_ready), 64'd0);
      @(posedge c1_clk0); #1;
      rst_n = 1'b1;
      clear_q();
      push_words(32, 400, cy);
      wait_wcmd(1);
      check_val("arst_strobes", 64'(wd_q.size()), 64'd32);
      if (wd_q.size() >= 1) check_val("arst_first", 64'(wd_q[0]), 64'd400);
      if (wa_q.size() >= 1) check_val("arst_cmd", 64'(wa_q[0]), 64'h0);
      clear_q();

      // Read job of 3 bursts at 0x400, with a rejected second start while busy.
      bus.rd_base   = 30'h400;
      bus.rd_bursts = 16'd3;
      bus.rd_start  = 1'b1;
      @(posedge c1_clk0); #1;
      bus.rd_start = 1'b0;
      check_val("rd_busy_set", 64'(bus.rd_busy), 64'd1);
      repeat (3) @(posedge c1_clk0); #1;
      bus.rd_base   = 30'h1000;
      bus.rd_bursts = 16'd1;
      bus.rd_start  = 1'b1;
      @(posedge c1_clk0); #1;
      bus.rd_start = 1'b0;
      g = 0;
      while (n_done < 1 && g < 1000) begin
         @(posedge c1_clk0); #1;
         g++;
      end
      repeat (60) @(posedge c1_clk0); #1;
      check_val("rd_done_cnt", 64'(n_done), 64'd1);
      check_val("rd_cmds", 64'(ra_q.size()), 64'd3);
      for (int k = 0; k < 3 && k < ra_q.size(); k++) begin
         check_val("rd_cmd_addr", 64'(ra_q[k]), 64'(30'h400 + 30'(k * 128)));
         check_val("rd_cmd_after", 64'(ra_at_q[k]), 64'(k * 32));
      end
      check_val("rd_out_cnt", 64'(n_out), 64'd96);
      if (out_q.size() >= 96) begin
         check_val("rd_out_first", 64'(out_q[0]), 64'h400);
         check_val("rd_out_last", 64'(out_q[95]), 64'h51f);
      end
      check_val("rd_done_timing", 64'(done_cyc), 64'(last_out_cyc + 1));
      check_val("rd_busy_clr", 64'(bus.rd_busy), 64'd0);

      // Zero-burst job: rd_done in the next cycle, no command.
      bus.rd_base   = 30'h800;
      bus.rd_bursts = 16'd0;
      bus.rd_start  = 1'b1;
      @(posedge c1_clk0); #1;
      bus.rd_start = 1'b0;
      @(negedge c1_clk0);
      check_val("rd0_done", 64'(bus.rd_done), 64'd1);
      repeat (5) @(posedge c1_clk0); #1;
      check_val("rd0_no_cmd", 64'(ra_q.size()), 64'd3);
      check_val("rd0_busy", 64'(bus.rd_busy), 64'd0);

      // Limit instance: 96 words offered against WR_LIMIT 0x100.
      lb.app_w_enable = 1'b1;
      lb.in_valid     = 1'b1;
      lim_acc         = 0;
      g               = 0;
      while (lim_acc < 96 && g < 200) begin
         @(negedge c1_clk0);
         acc = lb.in_valid && lb.in_ready && lb.app_w_enable;
         @(posedge c1_clk0); #1;
         g++;
         if (acc) lim_acc++;
         lb.in_data = 32'(lim_acc);
      end
      lb.in_valid = 1'b0;
      repeat (5) @(posedge c1_clk0); #1;
`ifdef DDR_BURST_SEQ_WRAP_EN
      check_val("lim_accepted", 64'(lim_acc), 64'd96);
      check_val("lim_strobes", 64'(lim_wd_n), 64'd96);
      check_val("lim_cmds", 64'(lim_wa_q.size()), 64'd3);
      if (lim_wa_q.size() >= 3) check_val("lim_wrap_cmd", 64'(lim_wa_q[2]), 64'h0);
      check_val("lim_wr_err", 64'(lb.wr_err), 64'd0);
`else
      check_val("lim_accepted", 64'(lim_acc), 64'd64);
      check_val("lim_strobes", 64'(lim_wd_n), 64'd64);
      check_val("lim_cmds", 64'(lim_wa_q.size()), 64'd2);
      check_val("lim_wr_err", 64'(lb.wr_err), 64'd1);
      check_val("lim_in_ready", 64'(lb.in_ready), 64'd0);
`endif
      if (lim_wa_q.size() >= 2) check_val("lim_cmd1", 64'(lim_wa_q[1]), 64'h80);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule
